// File: rtl/bsg_blackparrot_mc_link_scheduler.sv
// Shares the BlackParrot-side manycore request links among BP requesters with per-link
// round-robin arbitration, one-entry output registers, endpoint credits and a fence/drain FSM.
module bsg_blackparrot_mc_link_scheduler #(
  parameter int num_req_p     = 3,
  parameter int num_links_p   = 3,
  parameter int pkt_width_p   = 128,
  parameter int max_credits_p = 16,
  localparam int link_id_width_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1,
  localparam int credit_width_lp  = $clog2(max_credits_p + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0]       req_pkt_i,
  input  logic [num_req_p*link_id_width_lp-1:0]  req_link_i,
  output logic [num_req_p-1:0]                   req_yumi_o,
  output logic [num_links_p-1:0]                 link_v_o,
  output logic [num_links_p*pkt_width_p-1:0]     link_pkt_o,
  input  logic [num_links_p-1:0]                 link_ready_i,
  input  logic [num_links_p-1:0]                 credit_return_i,
  output logic [num_links_p*credit_width_lp-1:0] credits_o,
  input  logic                                   fence_i,
  output logic                                   fence_done_o,
  output logic                                   error_o
);

  localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [credit_width_lp-1:0] max_cred_lp = credit_width_lp'(max_credits_p);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_e;

  state_e                     state_r, state_next_s;
  logic [num_links_p-1:0]     valid_r;
  logic [pkt_width_p-1:0]     pkt_r     [num_links_p];
  logic [credit_width_lp-1:0] credits_r [num_links_p];
  logic [ptr_width_lp-1:0]    ptr_r     [num_links_p];
  logic                       error_r;

  logic                       grant_en_s;
  logic                       all_idle_s;
  logic                       err_s;
  logic [num_links_p-1:0]     slot_free_s;
  logic [num_links_p-1:0]     grant_s;
  logic [num_req_p-1:0]       yumi_s;
  logic [ptr_width_lp-1:0]    winner_s  [num_links_p];
  logic [pkt_width_p-1:0]     win_pkt_s [num_links_p];

  // The grant block applies in the very cycle fence_i is first seen, before the FSM moves.
  assign grant_en_s  = (state_r == RUN) && !fence_i && !reset_i;
  assign slot_free_s = ~valid_r | link_ready_i;

  // Per-link round-robin search starting at each link's pointer
  always_comb begin
    int  idx;
    logic hit;
    idx     = 0;
    hit     = 1'b0;
    grant_s = '0;
    yumi_s  = '0;
    for (int l = 0; l < num_links_p; l++) begin
      winner_s[l]  = '0;
      win_pkt_s[l] = '0;
      for (int k = 0; k < num_req_p; k++) begin
        idx = (int'(ptr_r[l]) + k) % num_req_p;
        hit = grant_en_s && slot_free_s[l] && (credits_r[l] != '0) && !grant_s[l] &&
              req_v_i[idx] &&
              (req_link_i[idx*link_id_width_lp +: link_id_width_lp] == link_id_width_lp'(l));
        winner_s[l]  = hit ? ptr_width_lp'(idx) : winner_s[l];
        win_pkt_s[l] = hit ? req_pkt_i[idx*pkt_width_p +: pkt_width_p] : win_pkt_s[l];
        grant_s[l]   = grant_s[l] | hit;
        yumi_s[idx]  = yumi_s[idx] | hit;
      end
    end
  end

  // Protocol errors and drain-complete detection
  always_comb begin
    err_s      = 1'b0;
    all_idle_s = (valid_r == '0);
    for (int r = 0; r < num_req_p; r++) begin
      err_s = err_s | (req_v_i[r] &&
              (int'(req_link_i[r*link_id_width_lp +: link_id_width_lp]) >= num_links_p));
    end
    for (int l = 0; l < num_links_p; l++) begin
      err_s      = err_s | (credit_return_i[l] && !grant_s[l] && (credits_r[l] == max_cred_lp));
      all_idle_s = all_idle_s && (credits_r[l] == max_cred_lp);
    end
  end

  // Fence FSM next-state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN:     state_next_s = fence_i ? DRAIN : RUN;
      DRAIN:   state_next_s = !fence_i ? RUN : (all_idle_s ? DONE : DRAIN);
      DONE:    state_next_s = fence_i ? DONE : RUN;
      default: state_next_s = RUN;
    endcase
  end

  // Output registers, pointers, credits, sticky error and FSM state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= RUN;
      valid_r <= '0;
      error_r <= 1'b0;
      for (int l = 0; l < num_links_p; l++) begin
        pkt_r[l]     <= '0;
        credits_r[l] <= max_cred_lp;
        ptr_r[l]     <= '0;
      end
    end else begin
      state_r <= state_next_s;
      error_r <= error_r | err_s;
      for (int l = 0; l < num_links_p; l++) begin
        if (grant_s[l]) begin
          valid_r[l] <= 1'b1;
          pkt_r[l]   <= win_pkt_s[l];
          ptr_r[l]   <= (int'(winner_s[l]) == num_req_p - 1) ? '0
                                                             : winner_s[l] + ptr_width_lp'(1);
        end else if (link_ready_i[l]) begin
          valid_r[l] <= 1'b0;
        end
        // A return arriving while already full is dropped and flagged through err_s.
        case ({grant_s[l], credit_return_i[l]})
          2'b10:   credits_r[l] <= credits_r[l] - credit_width_lp'(1);
          2'b01:   credits_r[l] <= (credits_r[l] == max_cred_lp) ? credits_r[l]
                                                                 : credits_r[l] + credit_width_lp'(1);
          default: credits_r[l] <= credits_r[l];
        endcase
      end
    end
  end

  // Flatten per-link registers onto the packed output buses
  always_comb begin
    link_pkt_o = '0;
    credits_o  = '0;
    for (int l = 0; l < num_links_p; l++) begin
      link_pkt_o[l*pkt_width_p +: pkt_width_p]     = pkt_r[l];
      credits_o[l*credit_width_lp +: credit_width_lp] = credits_r[l];
    end
  end

  assign req_yumi_o   = yumi_s;
  assign link_v_o     = valid_r;
  assign fence_done_o = (state_r == DONE);
  assign error_o      = error_r;

endmodule
